uart_error_collector: RTL and testbench
=======================================

# uart_error_collector

Host-side counterpart of the error-string UART transmitter. Receives 8N1 UART bytes at `BAUD_RATE` and assembles each burst of `FRAME_LEN` error bytes into one parallel frame. Bursts are delimited by line-idle gaps. Also serialises pause/resume command bytes (0x01 / 0x00) back to the transmitter, with the same baud timing. Sits at the board edge between the UART pins and the error-logging logic.

## Interface
Parameters:
- `Challenge_Bit`, 8: data bits per UART byte.
- `frequency_clk_ref`, 100: clk frequency in MHz.
- `BAUD_RATE`, 115200: line rate.
- `FRAME_LEN`, 15: bytes per error frame.
- `GAP_CYCLES`, `frequency_clk_ref*500`: idle-line cycles (0.5 ms) that delimit frames.

Ports:
- `clk`  in  1: sole clock.
- `reset`  in  1: asynchronous, active-high reset.
- `uart_rx`  in  1: serial input, asynchronous to clk.
- `pause_req`  in  1: level; high requests that the transmitter pause.
- `uart_tx`  out  1: serial command output, idles high.
- `frame_data`  out  `FRAME_LEN*Challenge_Bit`: last good frame; byte k at `[k*8+7:k*8]`, byte 0 first received.
- `frame_valid`  out  1: one-cycle pulse when `frame_data` updates.
- `frame_short`  out  1: one-cycle pulse when a gap ends a partial frame.
- `frame_err`  out  1: one-cycle pulse on a stop-bit error or an over-length frame.
- `paused`  out  1: last command byte fully sent was 0x01.

## Operation
- Bit period is `CLKS_PER_BIT = frequency_clk_ref*1000000/BAUD_RATE`, truncated (868 at defaults).
- **RX front end**
  - `uart_rx` passes through a 2-flop synchroniser.
  - A high-to-low edge while the receiver is idle starts a byte.
  - The start bit is re-sampled at `CLKS_PER_BIT/2`; if it is high, the edge is a glitch: return to idle, no byte.
  - Data bits are sampled LSB first at mid-bit, then the stop bit.
  - Stop bit = 0 is a framing error: the byte is dropped and treated as a frame error.
- **Gap counter**
  - Counts cycles while the receiver is idle and the synchronised line is high.
  - Clears on any start edge and saturates at `GAP_CYCLES`.
  - `gap` is true when the counter equals `GAP_CYCLES`.
- **Collector FSM**
  - HUNT (reset state): ignore all bytes; go to COLLECT when `gap` is true.
  - COLLECT: store each good byte at index `cnt` and increment `cnt`.
    - If `cnt` reaches `FRAME_LEN`: copy the buffer to `frame_data`, pulse `frame_valid`, go to HUNT.
    - On `gap` with 0 < `cnt` < `FRAME_LEN`: pulse `frame_short`, set `cnt`=0, stay in COLLECT.
    - On a framing error: pulse `frame_err`, set `cnt`=0, go to SKIP.
  - SKIP: discard all bytes; go to COLLECT (`cnt`=0) on `gap`.
  - A byte arriving in HUNT after a completed frame (burst longer than `FRAME_LEN`) pulses `frame_err` once per burst.
- **TX command engine**
  - `last_sent` resets to 0.
  - When idle and `pause_req != last_sent`: load byte {7'b0, `pause_req`}, send 8N1 (start, LSB first, stop).
  - `last_sent` and `paused` update at the end of the stop bit.
  - If `pause_req` toggles during a send, the current byte completes unaltered; the level is re-evaluated afterwards. A toggle pair within one byte time therefore sends nothing further.

## Timing
- Reset values: `uart_tx`=1, `frame_data`=0, `frame_valid`=`frame_short`=`frame_err`=0, `paused`=0. Reset also clears: FSM=HUNT, `cnt`=0, gap counter=0, RX and TX idle.
- Reset asserted mid-byte aborts both engines immediately; `uart_tx` returns high asynchronously.
- A byte is "good" on the cycle after its stop-bit sample.
- `frame_valid` is asserted on the cycle after the stop-bit sample of byte `FRAME_LEN-1`.
- `frame_data` is stable from the `frame_valid` cycle until the next `frame_valid`.
- Frame error and gap in the same cycle cannot occur (a gap requires an idle receiver); a stop-bit error takes effect at the stop-bit sample.
- Command-byte latency: the start bit drives `uart_tx` low 1 cycle after the `pause_req` change is seen while idle. The byte takes `10*CLKS_PER_BIT` cycles.
- RX latency from start edge to byte valid: about `9.5*CLKS_PER_BIT` + 3 cycles (synchroniser + register).

## Test plan
- **Good frame:** ≥0.5 ms idle, then 15 back-to-back bytes 0x41..0x4F → one `frame_valid`; `frame_data[7:0]`=0x41, `[119:112]`=0x4F; no error pulses.
- **Short frame:** idle, 10 bytes, then 0.5 ms idle → `frame_short` pulse; `frame_valid` stays low and `frame_data` is unchanged. A following full frame is accepted.
- **Framing error:** byte 5 of a frame sent with stop bit 0 → `frame_err` pulse and no `frame_valid` for that burst. After a gap, the next 15-byte frame yields `frame_valid`.
- **Mid-burst start:** release reset while a burst is in progress → bytes ignored until a gap (HUNT); the next full frame is accepted.
- **Pause command:** raise `pause_req` → `uart_tx` carries 0x01 (start, bits 1,0,0,0,0,0,0,0, stop) and `paused`=1 at the stop end. Lower it → 0x00 is sent and `paused`=0. Toggle high then low within one byte time while idle → only 0x01 is sent, followed by 0x00.
- **Reset mid-frame:** assert `reset` during byte 7 → all outputs at reset values; after release, a full frame following a gap is accepted.

Source files
------------

// File: rtl/uart_error_collector.sv
// Host-side UART error-frame collector: assembles bursts of FRAME_LEN bytes delimited by
// idle-line gaps into one parallel frame, and serialises pause/resume commands back.
module uart_error_collector #(
  parameter int Challenge_Bit     = 8,
  parameter int frequency_clk_ref = 100,
  parameter int BAUD_RATE         = 115200,
  parameter int FRAME_LEN         = 15,
  parameter int GAP_CYCLES        = frequency_clk_ref * 500
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               uart_rx,
  input  logic                               pause_req,
  output logic                               uart_tx,
  output logic [FRAME_LEN*Challenge_Bit-1:0] frame_data,
  output logic                               frame_valid,
  output logic                               frame_short,
  output logic                               frame_err,
  output logic                               paused
);

  localparam int CLKS_PER_BIT = frequency_clk_ref * 1000000 / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT + 1);
  localparam int BW           = $clog2(Challenge_Bit + 1);
  localparam int GW           = $clog2(GAP_CYCLES + 1);
  localparam int NW           = $clog2(FRAME_LEN + 1);
  localparam int FW           = FRAME_LEN * Challenge_Bit;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {HUNT, COLLECT, SKIP} col_state_e;

  // ---------------------------------------------------------------- RX front end
  rx_state_e              rx_state, rx_state_next;
  logic                   rx_meta, rx_sync, rx_prev;
  logic [CW-1:0]          rx_clk_cnt;
  logic [BW-1:0]          rx_bit_idx;
  logic [Challenge_Bit-1:0] rx_shift;
  logic                   start_edge, rx_half_tick, rx_bit_tick;
  logic                   byte_done, byte_ok;

  assign start_edge   = rx_prev & ~rx_sync;
  assign rx_half_tick = (rx_clk_cnt == CW'(HALF_BIT - 1));
  assign rx_bit_tick  = (rx_clk_cnt == CW'(CLKS_PER_BIT - 1));
  assign byte_ok      = rx_sync;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    rx_state_next = rx_state;
    byte_done     = 1'b0;
    case (rx_state)
      RX_IDLE:  if (start_edge) rx_state_next = RX_START;
      RX_START: if (rx_half_tick) rx_state_next = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_bit_tick && rx_bit_idx == BW'(Challenge_Bit - 1)) rx_state_next = RX_STOP;
      RX_STOP: begin
        if (rx_bit_tick) begin
          rx_state_next = RX_IDLE;
          byte_done     = 1'b1;
        end
      end
      default:  rx_state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (reset) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
      rx_state   <= RX_IDLE;
      rx_clk_cnt <= '0;
      rx_bit_idx <= '0;
      rx_shift   <= '0;
    end else begin
      rx_meta  <= uart_rx;
      rx_sync  <= rx_meta;
      rx_prev  <= rx_sync;
      rx_state <= rx_state_next;
      if (rx_state == RX_IDLE || rx_bit_tick || rx_state_next != rx_state)
        rx_clk_cnt <= '0;
      else
        rx_clk_cnt <= rx_clk_cnt + CW'(1);
      if (rx_state == RX_START)
        rx_bit_idx <= '0;
      if (rx_state == RX_DATA && rx_bit_tick) begin
        rx_shift   <= {rx_sync, rx_shift[Challenge_Bit-1:1]};
        rx_bit_idx <= rx_bit_idx + BW'(1);
      end
    end
  end

  // ---------------------------------------------------------------- gap counter
  logic [GW-1:0] gap_cnt;
  logic          gap;

  assign gap = (gap_cnt == GW'(GAP_CYCLES));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      gap_cnt <= '0;
    else if (rx_state == RX_IDLE && start_edge)
      gap_cnt <= '0;
    else if (rx_state == RX_IDLE && rx_sync && !gap)
      gap_cnt <= gap_cnt + GW'(1);
  end

  // ---------------------------------------------------------------- collector
  col_state_e    col_state, col_state_next;
  logic [NW-1:0] cnt, cnt_next;
  logic          over_armed, over_armed_next;
  logic          valid_next, short_next, err_next;
  logic          buf_we, frame_load;
  logic [FW-1:0] frame_buf, buf_next;

  // over_armed marks "a frame just completed"; the first extra byte of that burst is an error.
  always_comb begin
    col_state_next  = col_state;
    cnt_next        = cnt;
    over_armed_next = over_armed;
    valid_next      = 1'b0;
    short_next      = 1'b0;
    err_next        = 1'b0;
    buf_we          = 1'b0;
    frame_load      = 1'b0;
    buf_next        = frame_buf;
    buf_next[int'(cnt)*Challenge_Bit +: Challenge_Bit] = rx_shift;
    case (col_state)
      HUNT: begin
        if (byte_done && over_armed) begin
          err_next        = 1'b1;
          over_armed_next = 1'b0;
        end
        if (gap) begin
          col_state_next  = COLLECT;
          cnt_next        = '0;
          over_armed_next = 1'b0;
        end
      end
      COLLECT: begin
        if (byte_done) begin
          if (byte_ok) begin
            buf_we = 1'b1;
            if (cnt == NW'(FRAME_LEN - 1)) begin
              frame_load      = 1'b1;
              valid_next      = 1'b1;
              col_state_next  = HUNT;
              cnt_next        = '0;
              over_armed_next = 1'b1;
            end else begin
              cnt_next = cnt + NW'(1);
            end
          end else begin
            err_next       = 1'b1;
            cnt_next       = '0;
            col_state_next = SKIP;
          end
        end else if (gap && cnt != '0) begin
          short_next = 1'b1;
          cnt_next   = '0;
        end
      end
      SKIP: begin
        if (gap) begin
          col_state_next = COLLECT;
          cnt_next       = '0;
        end
      end
      default: col_state_next = HUNT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_state   <= HUNT;
      cnt         <= '0;
      over_armed  <= 1'b0;
      frame_valid <= 1'b0;
      frame_short <= 1'b0;
      frame_err   <= 1'b0;
      frame_data  <= '0;
    end else begin
      col_state   <= col_state_next;
      cnt         <= cnt_next;
      over_armed  <= over_armed_next;
      frame_valid <= valid_next;
      frame_short <= short_next;
      frame_err   <= err_next;
      if (frame_load)
        frame_data <= buf_next;
    end
  end

  // NOTE: the assembly buffer is not reset; cnt guarantees every byte is written before it is copied out.
  always_ff @(posedge clk) begin
    if (buf_we)
      frame_buf <= buf_next;
  end

  // ---------------------------------------------------------------- TX command engine
  tx_state_e                tx_state, tx_state_next;
  logic [CW-1:0]            tx_clk_cnt;
  logic [BW-1:0]            tx_bit_idx;
  logic [Challenge_Bit-1:0] tx_shift;
  logic                     tx_cmd, last_sent, tx_tick;

  assign tx_tick = (tx_clk_cnt == CW'(CLKS_PER_BIT - 1));
  assign paused  = last_sent;

  always_comb begin
    tx_state_next = tx_state;
    case (tx_state)
      TX_IDLE:  if (pause_req != last_sent) tx_state_next = TX_START;
      TX_START: if (tx_tick) tx_state_next = TX_DATA;
      TX_DATA:  if (tx_tick && tx_bit_idx == BW'(Challenge_Bit - 1)) tx_state_next = TX_STOP;
      TX_STOP:  if (tx_tick) tx_state_next = TX_IDLE;
      default:  tx_state_next = TX_IDLE;
    endcase
  end

  // The command bit is latched at start so a pause_req toggle mid-byte cannot alter it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state   <= TX_IDLE;
      tx_clk_cnt <= '0;
      tx_bit_idx <= '0;
      tx_shift   <= '0;
      tx_cmd     <= 1'b0;
      last_sent  <= 1'b0;
      uart_tx    <= 1'b1;
    end else begin
      tx_state <= tx_state_next;
      if (tx_state == TX_IDLE || tx_tick)
        tx_clk_cnt <= '0;
      else
        tx_clk_cnt <= tx_clk_cnt + CW'(1);
      case (tx_state)
        TX_IDLE: begin
          if (tx_state_next == TX_START) begin
            tx_shift <= {{(Challenge_Bit-1){1'b0}}, pause_req};
            tx_cmd   <= pause_req;
            uart_tx  <= 1'b0;
          end
        end
        TX_START: begin
          if (tx_tick) begin
            uart_tx    <= tx_shift[0];
            tx_bit_idx <= '0;
          end
        end
        TX_DATA: begin
          if (tx_tick) begin
            uart_tx    <= (tx_bit_idx == BW'(Challenge_Bit - 1)) ? 1'b1 : tx_shift[1];
            tx_shift   <= tx_shift >> 1;
            tx_bit_idx <= tx_bit_idx + BW'(1);
          end
        end
        TX_STOP: begin
          if (tx_tick)
            last_sent <= tx_cmd;
        end
        default: uart_tx <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_error_collector.sv
// Scoreboard bench for uart_error_collector: stimulus pushes expected frame events and
// command bytes; independent monitors pop and compare when the DUT produces them.
module tb_uart_error_collector;

  localparam int W        = 8;
  localparam int FL       = 15;
  localparam int FW       = FL * W;
  localparam int CPB      = 8;      // 100 MHz / 12.5 Mbaud
  localparam int GAP      = 100;
  localparam int IDLE_GAP = 250;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          uart_rx = 1'b1;
  logic          pause_req = 1'b0;
  logic          uart_tx;
  logic [FW-1:0] frame_data;
  logic          frame_valid, frame_short, frame_err, paused;

  uart_error_collector #(
    .Challenge_Bit    (W),
    .frequency_clk_ref(100),
    .BAUD_RATE        (12_500_000),
    .FRAME_LEN        (FL),
    .GAP_CYCLES       (GAP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .uart_rx    (uart_rx),
    .pause_req  (pause_req),
    .uart_tx    (uart_tx),
    .frame_data (frame_data),
    .frame_valid(frame_valid),
    .frame_short(frame_short),
    .frame_err  (frame_err),
    .paused     (paused)
  );

  always #5 clk = ~clk;

  typedef enum logic [1:0] {EV_VALID, EV_SHORT, EV_ERR} ev_kind_e;
  typedef struct {
    ev_kind_e      kind;
    logic [FW-1:0] data;
  } ev_t;

  ev_t           ev_q[$];
  logic [7:0]    tx_q[$];
  logic [FW-1:0] last_frame;
  logic [7:0]    tx_seen, tx_exp;
  int            checks = 0;
  int            passes = 0;

  task automatic check(input string name, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic logic [FW-1:0] frame_of(input logic [7:0] base);
    logic [FW-1:0] f;
    f = '0;
    for (int k = 0; k < FL; k++) f[k*W +: W] = base + 8'(k);
    return f;
  endfunction

  task automatic push_ev(input ev_kind_e kind, input logic [FW-1:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    ev_q.push_back(e);
  endtask

  task automatic idle(input int n);
    uart_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < W; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) send_byte(base + 8'(i), 1'b1);
  endtask

  task automatic wait_tx_drained();
    for (int i = 0; i < 2000 && tx_q.size() != 0; i++) @(negedge clk);
    check("tx_queue_drained", FW'(tx_q.size()), '0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_uart_tx"}, FW'(uart_tx), FW'(1));
    check({tag, "_frame_data"}, frame_data, '0);
    check({tag, "_frame_valid"}, FW'(frame_valid), '0);
    check({tag, "_frame_short"}, FW'(frame_short), '0);
    check({tag, "_frame_err"}, FW'(frame_err), '0);
    check({tag, "_paused"}, FW'(paused), '0);
  endtask

  task automatic handle_pulse(input ev_kind_e kind);
    ev_t e;
    if (ev_q.size() == 0) begin
      checks++;
      $display("FAIL unexpected_pulse: got kind %0d expected none", kind);
    end else begin
      e = ev_q.pop_front();
      check("event_kind", FW'(kind), FW'(e.kind));
      check("event_frame_data", frame_data, e.data);
    end
  endtask

  // Frame-event monitor
  initial begin
    forever begin
      @(negedge clk);
      if (frame_valid) handle_pulse(EV_VALID);
      if (frame_short) handle_pulse(EV_SHORT);
      if (frame_err)   handle_pulse(EV_ERR);
    end
  end

  // Command-line decoder: samples uart_tx at mid-bit and checks paused after the stop bit
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && uart_tx === 1'b0) begin
        repeat (CPB/2) @(negedge clk);
        check("tx_start_bit", FW'(uart_tx), '0);
        for (int i = 0; i < W; i++) begin
          repeat (CPB) @(negedge clk);
          tx_seen[i] = uart_tx;
        end
        repeat (CPB) @(negedge clk);
        check("tx_stop_bit", FW'(uart_tx), FW'(1));
        repeat (CPB/2) @(negedge clk);
        if (tx_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_tx_byte: got %h expected none", tx_seen);
        end else begin
          tx_exp = tx_q.pop_front();
          check("tx_byte", FW'(tx_seen), FW'(tx_exp));
          check("paused_after_stop", FW'(paused), FW'(tx_exp[0]));
        end
      end
    end
  end

  initial begin
    last_frame = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;

    // good frame
    idle(IDLE_GAP);
    last_frame = frame_of(8'h41);
    push_ev(EV_VALID, last_frame);
    send_frame(8'h41, FL);

    // short frame, data unchanged, then a full frame
    idle(IDLE_GAP);
    push_ev(EV_SHORT, last_frame);
    send_frame(8'h10, 10);
    idle(IDLE_GAP);
    last_frame = frame_of(8'h60);
    push_ev(EV_VALID, last_frame);
    send_frame(8'h60, FL);

    // stop-bit error on byte 5, rest of burst discarded, then recovery
    idle(IDLE_GAP);
    push_ev(EV_ERR, last_frame);
    for (int i = 0; i < FL; i++) send_byte(8'h80 + 8'(i), (i != 5));
    idle(IDLE_GAP);
    last_frame = frame_of(8'h90);
    push_ev(EV_VALID, last_frame);
    send_frame(8'h90, FL);

    // over-length burst: one frame, one error for the two extra bytes
    idle(IDLE_GAP);
    last_frame = frame_of(8'hA0);
    push_ev(EV_VALID, last_frame);
    push_ev(EV_ERR, last_frame);
    send_frame(8'hA0, FL + 2);
    idle(IDLE_GAP);

    // pause / resume commands
    tx_q.push_back(8'h01);
    pause_req = 1'b1;
    @(negedge clk);
    check("tx_latency_pause", FW'(uart_tx), '0);
    wait_tx_drained();
    check("paused_level_high", FW'(paused), FW'(1));

    tx_q.push_back(8'h00);
    pause_req = 1'b0;
    @(negedge clk);
    check("tx_latency_resume", FW'(uart_tx), '0);
    wait_tx_drained();
    check("paused_level_low", FW'(paused), '0);

    tx_q.push_back(8'h01);
    tx_q.push_back(8'h00);
    pause_req = 1'b1;
    @(negedge clk);
    check("tx_latency_toggle", FW'(uart_tx), '0);
    repeat (20) @(negedge clk);
    pause_req = 1'b0;
    wait_tx_drained();
    check("paused_after_toggle", FW'(paused), '0);

    // reset released in the middle of a burst: burst ignored, next frame accepted
    reset = 1'b1;
    last_frame = '0;
    fork
      send_frame(8'hC0, FL);
      begin
        repeat (250) @(negedge clk);
        reset = 1'b0;
      end
    join
    idle(IDLE_GAP);
    last_frame = frame_of(8'hD0);
    push_ev(EV_VALID, last_frame);
    send_frame(8'hD0, FL);

    // reset during byte 7
    idle(IDLE_GAP);
    send_frame(8'hE0, 7);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2*CPB) @(negedge clk);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    reset = 1'b1;
    last_frame = '0;
    #1;
    check_reset_outputs("midframe_reset");
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    idle(IDLE_GAP);
    last_frame = frame_of(8'hF0);
    push_ev(EV_VALID, last_frame);
    send_frame(8'hF0, FL);

    idle(50);
    for (int i = 0; i < 5000 && (ev_q.size() != 0 || tx_q.size() != 0); i++) @(negedge clk);
    check("events_drained", FW'(ev_q.size()), '0);
    check("tx_bytes_drained", FW'(tx_q.size()), '0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
